// File: rtl/mcu_spi_sel_pkg.sv
// Purpose: shared types and idle levels for the MCU SPI port selector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mcu_spi_sel_pkg;

    // Port-select FSM states.
    typedef enum logic [1:0] {
        INT    = 2'd0,
        TO_EXT = 2'd1,
        EXT    = 2'd2,
        TO_INT = 2'd3
    } state_t;

    // Levels presented to the SPI slave while no MCU is selected.
    localparam logic CSN_IDLE  = 1'b1;
    localparam logic SCLK_IDLE = 1'b0;
    localparam logic MOSI_IDLE = 1'b0;

endpackage

// File: rtl/mcu_spi_port_sel_sync_bit.sv
// Purpose: multi-flop synchroniser for one asynchronous MCU pin.
// Latency: STAGES cycles from d to q.
// Backpressure: none; samples every cycle.
module sync_bit #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk32,
    input  logic por,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;

    // Shift the pin through the chain; reset parks it at the pin's idle level.
    always_ff @(posedge clk32) begin
        if (por) begin
            r_sync <= {STAGES{RESET_VAL}};
        end else begin
            r_sync <= {r_sync[STAGES-2:0], d};
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/mcu_spi_port_sel.sv
// Purpose: frame-safe selection between the on-board and external MCU SPI masters.
// Latency: SYNC_STAGES+1 cycles from pin to mcu_* outputs.
// Backpressure: none; switching only waits on SPI frame boundaries (CSn high).
module mcu_spi_port_sel
    import mcu_spi_sel_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int DETECT_CYCLES = 4,
    parameter int GUARD_CYCLES  = 8,
    parameter int REVERT_CYCLES = 0
) (
    input  logic clk32,
    input  logic por,
    input  logic int_sclk,
    input  logic int_csn,
    input  logic int_mosi,
    input  logic ext_sclk,
    input  logic ext_csn,
    input  logic ext_mosi,
    output logic mcu_sclk,
    output logic mcu_csn,
    output logic mcu_mosi,
    output logic ext_active,
    output logic switching
);

    localparam int DW = $clog2(DETECT_CYCLES + 1);
    localparam int GW = $clog2(GUARD_CYCLES + 1);
    // A zero revert count still needs a 1-bit counter to keep the code uniform.
    localparam int RW = (REVERT_CYCLES > 0) ? $clog2(REVERT_CYCLES + 1) : 1;

    localparam logic [DW-1:0] DET_MAX   = DW'(DETECT_CYCLES);
    localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_CYCLES);
    localparam logic [RW-1:0] IDLE_MAX  = RW'(REVERT_CYCLES);

    logic w_int_sclk_s, w_int_csn_s, w_int_mosi_s;
    logic w_ext_sclk_s, w_ext_csn_s, w_ext_mosi_s;
    logic w_revert;

    state_t        r_state;
    logic          r_ext_seen;
    logic [DW-1:0] r_det_cnt;
    logic [GW-1:0] r_guard_cnt;
    logic [RW-1:0] r_idle_cnt;
    logic          r_csn, r_sclk, r_mosi;
    logic          r_ext_active, r_switching;

    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sync_int_sclk (
        .clk32(clk32), .por(por), .d(int_sclk), .q(w_int_sclk_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(CSN_IDLE)) u_sync_int_csn (
        .clk32(clk32), .por(por), .d(int_csn), .q(w_int_csn_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_int_mosi (
        .clk32(clk32), .por(por), .d(int_mosi), .q(w_int_mosi_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(SCLK_IDLE)) u_sync_ext_sclk (
        .clk32(clk32), .por(por), .d(ext_sclk), .q(w_ext_sclk_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(CSN_IDLE)) u_sync_ext_csn (
        .clk32(clk32), .por(por), .d(ext_csn), .q(w_ext_csn_s));
    sync_bit #(.STAGES(SYNC_STAGES), .RESET_VAL(MOSI_IDLE)) u_sync_ext_mosi (
        .clk32(clk32), .por(por), .d(ext_mosi), .q(w_ext_mosi_s));

    // Revert only when enabled, after enough external idle, and between internal frames.
    assign w_revert = (REVERT_CYCLES > 0) && (r_idle_cnt == IDLE_MAX) && w_int_csn_s;

    // Port-select FSM with its counters and the registered output mux.
    always_ff @(posedge clk32) begin
        if (por) begin
            r_state      <= INT;
            r_ext_seen   <= 1'b0;
            r_det_cnt    <= '0;
            r_guard_cnt  <= '0;
            r_idle_cnt   <= '0;
            r_csn        <= CSN_IDLE;
            r_sclk       <= SCLK_IDLE;
            r_mosi       <= MOSI_IDLE;
            r_ext_active <= 1'b0;
            r_switching  <= 1'b0;
        end else begin
            case (r_state)
                INT: begin
                    // Sticky detection needs a sustained external CSn low, so short glitches are ignored.
                    if (!w_ext_csn_s) begin
                        if (r_det_cnt != DET_MAX) r_det_cnt <= r_det_cnt + 1'b1;
                        if (r_det_cnt >= DET_MAX - 1'b1) r_ext_seen <= 1'b1;
                    end else begin
                        r_det_cnt <= '0;
                    end
                    // Leave only between internal frames so none is truncated.
                    if (r_ext_seen && w_int_csn_s) begin
                        r_state     <= TO_EXT;
                        r_guard_cnt <= '0;
                        r_switching <= 1'b1;
                        r_csn       <= CSN_IDLE;
                        r_sclk      <= SCLK_IDLE;
                        r_mosi      <= MOSI_IDLE;
                    end else begin
                        r_csn       <= w_int_csn_s;
                        r_sclk      <= w_int_sclk_s;
                        r_mosi      <= w_int_mosi_s;
                    end
                end
                TO_EXT: begin
                    // Hold idle for the guard time, then wait for an external frame boundary.
                    if ((r_guard_cnt == GUARD_MAX) && w_ext_csn_s) begin
                        r_state      <= EXT;
                        r_idle_cnt   <= '0;
                        r_switching  <= 1'b0;
                        r_ext_active <= 1'b1;
                        r_csn        <= w_ext_csn_s;
                        r_sclk       <= w_ext_sclk_s;
                        r_mosi       <= w_ext_mosi_s;
                    end else if (r_guard_cnt != GUARD_MAX) begin
                        r_guard_cnt <= r_guard_cnt + 1'b1;
                    end
                end
                EXT: begin
                    if (w_ext_csn_s) begin
                        if (r_idle_cnt != IDLE_MAX) r_idle_cnt <= r_idle_cnt + 1'b1;
                    end else begin
                        r_idle_cnt <= '0;
                    end
                    if (w_revert) begin
                        r_state      <= TO_INT;
                        r_ext_seen   <= 1'b0;
                        r_guard_cnt  <= '0;
                        r_switching  <= 1'b1;
                        r_ext_active <= 1'b0;
                        r_csn        <= CSN_IDLE;
                        r_sclk       <= SCLK_IDLE;
                        r_mosi       <= MOSI_IDLE;
                    end else begin
                        r_csn        <= w_ext_csn_s;
                        r_sclk       <= w_ext_sclk_s;
                        r_mosi       <= w_ext_mosi_s;
                    end
                end
                TO_INT: begin
                    // Detection starts fresh once the internal port is back.
                    if ((r_guard_cnt == GUARD_MAX) && w_int_csn_s) begin
                        r_state     <= INT;
                        r_det_cnt   <= '0;
                        r_switching <= 1'b0;
                        r_csn       <= w_int_csn_s;
                        r_sclk      <= w_int_sclk_s;
                        r_mosi      <= w_int_mosi_s;
                    end else if (r_guard_cnt != GUARD_MAX) begin
                        r_guard_cnt <= r_guard_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state      <= INT;
                    r_switching  <= 1'b0;
                    r_ext_active <= 1'b0;
                    r_csn        <= CSN_IDLE;
                    r_sclk       <= SCLK_IDLE;
                    r_mosi       <= MOSI_IDLE;
                end
            endcase
        end
    end

    assign mcu_csn    = r_csn;
    assign mcu_sclk   = r_sclk;
    assign mcu_mosi   = r_mosi;
    assign ext_active = r_ext_active;
    assign switching  = r_switching;

endmodule

// File: tb/tb_mcu_spi_port_sel.sv
// Purpose: directed self-checking bench for mcu_spi_port_sel (no-revert and revert builds side by side).
// Latency: expects SYNC_STAGES+1 = 3 cycles pin to output.
// Backpressure: n/a.
module tb_mcu_spi_port_sel;

    localparam logic [2:0] IDLE3 = 3'b100;   // {csn, sclk, mosi}

    logic clk32 = 1'b0;
    logic por   = 1'b1;
    logic int_sclk = 1'b0, int_csn = 1'b1, int_mosi = 1'b0;
    logic ext_sclk = 1'b0, ext_csn = 1'b1, ext_mosi = 1'b0;
    logic a_sclk, a_csn, a_mosi, a_act, a_sw;
    logic b_sclk, b_csn, b_mosi, b_act, b_sw;

    int checks   = 0;
    int failures = 0;

    // Driven-value history, index 2 is what should be on the outputs now.
    logic [2:0] hi [3];
    logic [2:0] he [3];

    always #5 clk32 = ~clk32;

    mcu_spi_port_sel #(.SYNC_STAGES(2), .DETECT_CYCLES(4), .GUARD_CYCLES(8), .REVERT_CYCLES(0)) u_dut_a (
        .clk32(clk32), .por(por),
        .int_sclk(int_sclk), .int_csn(int_csn), .int_mosi(int_mosi),
        .ext_sclk(ext_sclk), .ext_csn(ext_csn), .ext_mosi(ext_mosi),
        .mcu_sclk(a_sclk), .mcu_csn(a_csn), .mcu_mosi(a_mosi),
        .ext_active(a_act), .switching(a_sw));

    mcu_spi_port_sel #(.SYNC_STAGES(2), .DETECT_CYCLES(4), .GUARD_CYCLES(8), .REVERT_CYCLES(100)) u_dut_b (
        .clk32(clk32), .por(por),
        .int_sclk(int_sclk), .int_csn(int_csn), .int_mosi(int_mosi),
        .ext_sclk(ext_sclk), .ext_csn(ext_csn), .ext_mosi(ext_mosi),
        .mcu_sclk(b_sclk), .mcu_csn(b_csn), .mcu_mosi(b_mosi),
        .ext_active(b_act), .switching(b_sw));

    // SPI mode-0 frame, MSB first: setup, 8 x (low, high), hold, CSn release.
    function automatic logic [2:0] fvec(input logic [7:0] b, input int i);
        logic s;
        if (i == 0 || i == 17) return 3'b000;
        if (i >= 18) return IDLE3;
        s = (((i - 1) % 2) == 1);
        return {1'b0, s, b[7 - (i - 1) / 2]};
    endfunction

    task automatic cyc(input logic [2:0] iv, input logic [2:0] ev);
        {int_csn, int_sclk, int_mosi} = iv;
        {ext_csn, ext_sclk, ext_mosi} = ev;
        @(posedge clk32);
        #1;
        hi[2] = hi[1]; hi[1] = hi[0]; hi[0] = iv;
        he[2] = he[1]; he[1] = he[0]; he[0] = ev;
    endtask

    // sel: 0 = delayed internal pins, 1 = delayed external pins, 2 = idle.
    task automatic chk_out(input string tag, input int inst, input int sel, input logic ea, input logic sw);
        logic [4:0] obs, exp;
        logic [2:0] d;
        if (sel == 0) d = hi[2];
        else if (sel == 1) d = he[2];
        else d = IDLE3;
        if (inst == 0) obs = {a_csn, a_sclk, a_mosi, a_act, a_sw};
        else obs = {b_csn, b_sclk, b_mosi, b_act, b_sw};
        exp = {d, ea, sw};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s inst=%0d observed={csn,sclk,mosi,act,sw}=%b expected=%b", tag, inst, obs, exp);
        end
    endtask

    task automatic chk_flag(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic frame(input string tag, input bit on_ext, input logic [7:0] b,
                         input int sel_a, input logic ea_a, input logic sw_a,
                         input int sel_b, input logic ea_b, input logic sw_b, input int ntrail);
        logic [2:0] v;
        for (int i = 0; i < 19 + ntrail; i++) begin
            v = (i < 19) ? fvec(b, i) : IDLE3;
            if (on_ext) cyc(IDLE3, v);
            else cyc(v, IDLE3);
            chk_out(tag, 0, sel_a, ea_a, sw_a);
            chk_out(tag, 1, sel_b, ea_b, sw_b);
        end
    endtask

    task automatic do_reset(input int n);
        por = 1'b1;
        for (int i = 0; i < n; i++) cyc(IDLE3, IDLE3);
        por = 1'b0;
    endtask

    initial begin
        int  sw_cnt;
        bit  found;
        bit  bad;
        for (int i = 0; i < 3; i++) begin
            hi[i] = IDLE3;
            he[i] = IDLE3;
        end

        // Reset state.
        do_reset(4);
        chk_out("reset", 0, 2, 1'b0, 1'b0);
        chk_out("reset", 1, 2, 1'b0, 1'b0);

        // Internal pass-through of 0xA5.
        frame("int_pass_a5", 1'b0, 8'hA5, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 3);

        // External glitch shorter than the detect window.
        for (int i = 0; i < 3; i++) begin
            cyc(IDLE3, 3'b000);
            chk_out("deglitch_low", 0, 0, 1'b0, 1'b0);
        end
        for (int i = 0; i < 12; i++) begin
            cyc(IDLE3, IDLE3);
            chk_out("deglitch_after", 0, 0, 1'b0, 1'b0);
            chk_out("deglitch_after", 1, 0, 1'b0, 1'b0);
        end

        // Switch to the external port: 6 cycles of ext CSn low.
        for (int i = 0; i < 6; i++) begin
            cyc(IDLE3, 3'b000);
            chk_out("detect_low", 0, 0, 1'b0, 1'b0);
        end
        sw_cnt = 0;
        found  = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cyc(IDLE3, IDLE3);
            if (a_sw) sw_cnt++;
            if (a_act) begin
                found = 1'b1;
                break;
            end
        end
        chk_flag("reach_ext", found, 1'b1);
        checks++;
        assert (sw_cnt >= 8 && sw_cnt <= 9) else begin
            failures++;
            $error("FAIL guard_len observed=%0d expected=8..9", sw_cnt);
        end
        chk_out("in_ext", 0, 1, 1'b1, 1'b0);

        // External frame 0x3C passes; an internal frame is ignored while external is selected.
        frame("ext_pass_3c", 1'b1, 8'h3C, 1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 3);
        frame("ext_ignore_int", 1'b0, 8'h5A, 1, 1'b1, 1'b0, 1, 1'b1, 1'b0, 3);

        // Revert after external idle (revert build only).
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            cyc(IDLE3, IDLE3);
            if (b_sw) begin
                found = 1'b1;
                break;
            end
        end
        chk_flag("revert_start", found, 1'b1);
        chk_out("revert_guard", 1, 2, 1'b0, 1'b1);
        chk_out("no_revert", 0, 1, 1'b1, 1'b0);
        found = 1'b0;
        for (int n = 0; n < 30; n++) begin
            cyc(IDLE3, IDLE3);
            if (!b_sw) begin
                found = 1'b1;
                break;
            end
        end
        chk_flag("revert_done", found, 1'b1);
        chk_out("back_int", 1, 0, 1'b0, 1'b0);
        frame("after_revert_81", 1'b0, 8'h81, 1, 1'b1, 1'b0, 0, 1'b0, 1'b0, 3);

        // No-revert build stays external for a long idle stretch.
        bad = 1'b0;
        for (int n = 0; n < 10000; n++) begin
            cyc(IDLE3, IDLE3);
            if (a_act !== 1'b1 || a_sw !== 1'b0) bad = 1'b1;
        end
        chk_flag("ext_terminal", bad, 1'b0);

        // Reset pulse in the middle of an external frame.
        for (int i = 0; i < 19; i++) begin
            por = (i == 6);
            cyc(IDLE3, fvec(8'h96, i));
            if (i < 6) begin
                chk_out("pre_por", 0, 1, 1'b1, 1'b0);
                chk_out("pre_por", 1, 0, 1'b0, 1'b0);
            end else if (i <= 7) begin
                chk_out("por_mid", 0, 2, 1'b0, 1'b0);
                chk_out("por_mid", 1, 2, 1'b0, 1'b0);
            end
        end
        por = 1'b0;
        do_reset(3);

        // Detection during an internal frame must not cut it short.
        for (int i = 0; i < 19; i++) begin
            cyc(fvec(8'hFF, i), (i >= 3 && i < 9) ? 3'b000 : IDLE3);
            chk_out("protect_ff", 0, 0, 1'b0, 1'b0);
            chk_out("protect_ff", 1, 0, 1'b0, 1'b0);
        end
        cyc(IDLE3, IDLE3);
        chk_out("protect_tail", 0, 0, 1'b0, 1'b0);
        cyc(IDLE3, IDLE3);
        chk_out("protect_switch", 0, 2, 1'b0, 1'b1);
        chk_out("protect_switch", 1, 2, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_spi_port_sel.md
Name: mcu_spi_port_sel

Overview:
- Selects which MCU drives the FPGA's MCU SPI slave interface: the on-board BL616 (internal) or an external M0S Dock.
- Replaces the ad-hoc "switch to M0S on first CSn low" latch with a clean, frame-boundary-safe port switch.
- Synchronises and deglitches both MCU ports, switches only between SPI frames, and can optionally revert to the internal MCU after external inactivity.
- Sits between the top-level pins and the misterynano mcu_sclk/mcu_csn/mcu_mosi inputs. MISO and INTn fan-out to both MCUs stays outside this block.

Parameters:
- SYNC_STAGES, 2: synchroniser flops per input; must be >=2.
- DETECT_CYCLES, 4: consecutive cycles of synchronised ext_csn low needed to detect an external MCU; must be >=1.
- GUARD_CYCLES, 8: cycles outputs are forced idle during a switch; must be >=1.
- REVERT_CYCLES, 0: cycles of external idle (ext_csn high) before reverting to internal; 0 disables revert.

Ports:
- clk32  in  1  32 MHz system clock.
- por  in  1  synchronous, active-high reset.
- int_sclk  in  1  SPI clock from on-board BL616.
- int_csn  in  1  SPI select from on-board BL616, active low.
- int_mosi  in  1  SPI data from on-board BL616.
- ext_sclk  in  1  SPI clock from M0S Dock.
- ext_csn  in  1  SPI select from M0S Dock, active low.
- ext_mosi  in  1  SPI data from M0S Dock.
- mcu_sclk  out  1  selected SPI clock, registered.
- mcu_csn  out  1  selected SPI select, registered.
- mcu_mosi  out  1  selected SPI data, registered.
- ext_active  out  1  1 while the external port is selected (state EXT).
- switching  out  1  1 during guard states TO_EXT and TO_INT.

Behaviour:
- Single clock clk32. Reset is synchronous and active-high on por; every flop resets on por.
- Synchronisers: each input passes through SYNC_STAGES flops.
  - Reset values: csn=1, sclk=0, mosi=0.
  - Signals ending in _s below are the synchroniser outputs.
- Output register: pin-to-output latency is SYNC_STAGES+1 cycles (3 at default).
- Idle output value: mcu_csn=1, mcu_sclk=0, mcu_mosi=0.
- Reset values:
  - mcu_csn=1, mcu_sclk=0, mcu_mosi=0.
  - ext_active=0, switching=0.
  - state=INT, ext_seen=0, all counters 0.
- Detect counter (runs in INT only):
  - Increments while ext_csn_s=0 and saturates at DETECT_CYCLES.
  - Clears when ext_csn_s=1.
  - Reaching DETECT_CYCLES sets sticky flag ext_seen.
  - Glitches shorter than DETECT_CYCLES do not set ext_seen.
- INT state:
  - Outputs = int_*_s.
  - Go to TO_EXT when ext_seen=1 and int_csn_s=1. An internal frame in progress is never truncated.
- TO_EXT state:
  - Outputs forced idle; switching=1; guard counter runs.
  - Go to EXT when guard count reaches GUARD_CYCLES and ext_csn_s=1.
  - This waits for an external frame boundary. The external frame that triggered detection is dropped, and the MCU firmware retries it.
- EXT state:
  - Outputs = ext_*_s; ext_active=1.
  - If REVERT_CYCLES>0: idle counter increments while ext_csn_s=1 (saturating) and clears when ext_csn_s=0.
  - At REVERT_CYCLES with int_csn_s=1: go to TO_INT and clear ext_seen.
  - If REVERT_CYCLES=0: EXT is terminal until por.
- TO_INT state:
  - Outputs forced idle; switching=1.
  - Go to INT when guard count reaches GUARD_CYCLES and int_csn_s=1.
  - The detect counter restarts from 0 on entry to INT.
- Simultaneous activity: in INT, both CSn low means internal stays selected. The switch happens after int_csn_s rises, provided ext_seen=1.
- Guard counter: clears on entry to each guard state and saturates at GUARD_CYCLES.
- Counter widths: $clog2(param+1). Saturation must prevent wrap-around for all counters.
- por mid-operation: the next cycle is INT with idle outputs. Synchronisers are cleared, so selected data resumes SYNC_STAGES+1 cycles later.
- No combinational path from any input to any output.

Decomposition:
- Package mcu_spi_sel_pkg contains:
  - state enum: INT, TO_EXT, EXT, TO_INT (2 bits).
  - idle constants: CSN_IDLE=1, SCLK_IDLE=0, MOSI_IDLE=0.
- One sub-module: sync_bit.
  - Parameters STAGES and RESET_VAL; ports clk32, por, d, q.
  - Instantiated six times.
- FSM, counters and output mux live in mcu_spi_port_sel.

Test Plan:
- Internal pass-through: after por, ext_csn=1 and an internal 8-bit frame 0xA5 on int_* → identical waveform on mcu_* delayed 3 cycles; ext_active=0, switching=0 throughout.
- Deglitch: ext_csn low for 3 cycles (DETECT_CYCLES=4) → ext_seen stays 0, state stays INT, no switching pulse.
- Switch: ext_csn low for 6 cycles then high, int_csn high → switching=1 for >=8 cycles, then ext_active=1. The next external frame 0x3C appears on mcu_* with 3-cycle latency.
- Frame protection: external detect fires while int_csn is low mid-frame 0xFF → mcu_* completes the internal frame bit-exact. switching rises only after int_csn_s rises.
- Revert:
  - REVERT_CYCLES=100, in EXT, ext_csn held high 100 cycles, int_csn high → TO_INT, guard, then INT with ext_active=0.
  - Same stimulus with REVERT_CYCLES=0 → stays in EXT for 10000 cycles.
- Reset mid-operation: por pulsed 1 cycle while in EXT and mid-frame → the next cycle has mcu_csn=1, mcu_sclk=0, ext_active=0, switching=0, state INT.
